// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states and architectural constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam REG_ZERO = '0;
  localparam logic [6:0] HALT_OPC = 7'b1111111;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use match between the ID sources and a load in EX.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it has no consumer.
  assign rd_live  = ex_rd != REG_AW'(REG_ZERO);
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and halt sequencer: redirect flushes, load-use stalls, halt drain FSM
// and a saturating load-use stall counter.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_halt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_pc_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  hz_state_t  state;
  hz_state_t  state_nx;
  logic [3:0] drain_cnt;
  logic [3:0] drain_nx;
  logic       load_use;
  logic       count_stall;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lud (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_nx    = state;
    drain_nx    = drain_cnt;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    count_stall = 1'b0;
    case (state)
      RUN: begin
        // A redirect kills the ID instruction, so its hazards and halt are moot.
        if (ex_pc_sel) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          count_stall = 1'b1;
        end else if (id_halt) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_nx    = DRAIN;
          drain_nx    = DRAIN_INIT;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if (drain_cnt == 4'd0) begin
          state_nx = HALTED;
        end else begin
          drain_nx = drain_cnt - 4'd1;
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      drain_cnt   <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
      if (count_stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
